// File: rtl/band_mixer_pkg.sv
// Shared vocoder synthesis-side definitions: mixer FSM states, saturation
// limits for arbitrary sample widths, and accumulator sizing.
package band_mixer_pkg;

    // Mixer control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } mix_state_t;

    // Width of the limit constants returned below (covers any sample up to 64 bits)
    localparam int unsigned LIMIT_W = 64;

    // Most positive two's complement value representable in w bits
    function automatic logic signed [LIMIT_W-1:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative two's complement value representable in w bits
    function automatic logic signed [LIMIT_W-1:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    // Accumulator width that cannot wrap when n full-width products are summed
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
        return 2 * w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/band_mixer_sat_shift.sv
// sat_shift: arithmetic right shift of a wide accumulator followed by
// saturation into a narrower signed sample. Purely combinational.
//   acc    : IN_WIDTH signed accumulator value
//   result : OUT_WIDTH signed, (acc >>> SHIFT) clipped to the OUT_WIDTH range
module sat_shift
    import band_mixer_pkg::*;
#(
    parameter int unsigned IN_WIDTH  = 52,
    parameter int unsigned OUT_WIDTH = 24,
    parameter int unsigned SHIFT     = 20
) (
    input  logic signed [IN_WIDTH-1:0]  acc,
    output logic signed [OUT_WIDTH-1:0] result
);

    localparam int unsigned UPPER_W = IN_WIDTH - OUT_WIDTH + 1;

    logic signed [IN_WIDTH-1:0] shifted;
    logic        [UPPER_W-1:0]  upper;
    logic                       fits;

    // Value fits when every bit above the output sign bit matches it
    always_comb begin
        shifted = acc >>> SHIFT;
        upper   = shifted[IN_WIDTH-1:OUT_WIDTH-1];
        fits    = (&upper) | ~(|upper);
        if (fits) begin
            result = shifted[OUT_WIDTH-1:0];
        end else if (shifted[IN_WIDTH-1]) begin
            result = OUT_WIDTH'(sat_min(OUT_WIDTH));
        end else begin
            result = OUT_WIDTH'(sat_max(OUT_WIDTH));
        end
    end

endmodule

// File: rtl/band_mixer.sv
// band_mixer: vocoder synthesis mixer. Captures one frame of NUM_BANDS
// carrier/envelope pairs, accumulates carrier[k] * max(envelope[k], 0) over
// the bands with a single time-shared multiplier, then shifts and saturates
// the sum into one output sample.
//   clk_in      : clock, rising edge
//   rst_in      : asynchronous active-high reset
//   valid_in    : frame strobe for carrier_in / envelope_in
//   carrier_in  : NUM_BANDS packed signed carrier samples (band k at k*WIDTH)
//   envelope_in : NUM_BANDS packed signed envelope values, same packing
//   sample_out  : mixed output sample, held between valid_out pulses
//   valid_out   : one-cycle strobe qualifying sample_out
//   busy_out    : high while a frame is being accumulated
//   overrun_out : one-cycle pulse after a valid_in that arrived while busy
module band_mixer
    import band_mixer_pkg::*;
#(
    parameter int unsigned WIDTH     = 24,
    parameter int unsigned SHIFT     = 20,
    parameter int unsigned NUM_BANDS = 8
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          valid_in,
    input  logic [NUM_BANDS*WIDTH-1:0]    carrier_in,
    input  logic [NUM_BANDS*WIDTH-1:0]    envelope_in,
    output logic signed [WIDTH-1:0]       sample_out,
    output logic                          valid_out,
    output logic                          busy_out,
    output logic                          overrun_out
);

    localparam int unsigned ACC_W  = acc_width(WIDTH, NUM_BANDS);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS - 1);

    mix_state_t                state;
    logic [IDX_W-1:0]          idx;
    logic signed [ACC_W-1:0]   acc;

    logic signed [WIDTH-1:0]   car_buf [NUM_BANDS];
    logic signed [WIDTH-1:0]   env_buf [NUM_BANDS];

    logic signed [WIDTH-1:0]   car_sel;
    logic signed [WIDTH-1:0]   env_sel;
    logic signed [WIDTH-1:0]   env_pos;
    logic signed [PROD_W-1:0]  product;
    logic signed [WIDTH-1:0]   sat_sample;

    // Frame buffer: loaded only on an accepted frame, otherwise untouched
    always_ff @(posedge clk_in) begin
        if (state == ST_IDLE && valid_in) begin
            for (int k = 0; k < int'(NUM_BANDS); k++) begin
                car_buf[k] <= carrier_in[k*WIDTH +: WIDTH];
                env_buf[k] <= envelope_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Single shared multiplier; negative envelopes contribute nothing
    always_comb begin
        car_sel = car_buf[idx];
        env_sel = env_buf[idx];
        env_pos = env_sel[WIDTH-1] ? '0 : env_sel;
        product = car_sel * env_pos;
    end

    sat_shift #(
        .IN_WIDTH  (ACC_W),
        .OUT_WIDTH (WIDTH),
        .SHIFT     (SHIFT)
    ) u_sat_shift (
        .acc    (acc),
        .result (sat_sample)
    );

    // Control FSM with registered outputs
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            idx         <= '0;
            acc         <= '0;
            sample_out  <= '0;
            valid_out   <= 1'b0;
            busy_out    <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid_in) begin
                        acc      <= '0;
                        idx      <= '0;
                        busy_out <= 1'b1;
                        state    <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + ACC_W'(product);
                    if (valid_in) begin
                        overrun_out <= 1'b1;
                    end
                    // Index parks on the last band; only a new capture rewinds it
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    sample_out <= sat_sample;
                    valid_out  <= 1'b1;
                    busy_out   <= 1'b0;
                    // A frame offered on the return-to-idle edge is still rejected
                    if (valid_in) begin
                        overrun_out <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
